// File: rtl/dice_roll_engine.sv
// Parametrised dice roller: uniform draws by rejection from a free-running LFSR,
// per-turn roll budget, and a one-cycle completion pulse.
module dice_roll_engine #(
    parameter int          N_DICE    = 5,
    parameter int          FACES     = 6,
    parameter int          VAL_W     = 3,
    parameter int          MAX_ROLLS = 3,
    parameter int          MAX_RETRY = 7,
    parameter logic [31:0] LFSR_SEED = 32'h0000ACE1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           roll_req,
    input  logic                           new_turn,
    input  logic [N_DICE-1:0]              hold,
    output logic [N_DICE*VAL_W-1:0]        dice_vals,
    output logic                           busy,
    output logic                           roll_done,
    output logic [$clog2(MAX_ROLLS+1)-1:0] rolls_left,
    output logic                           first_roll
);

    localparam int IDX_W   = (N_DICE > 1) ? $clog2(N_DICE) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int RL_W    = $clog2(MAX_ROLLS + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_DICE - 1);
    localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);
    localparam logic [RL_W-1:0]    MAX_ROLLS_V = RL_W'(MAX_ROLLS);
    localparam logic [VAL_W:0]     FACES_V     = (VAL_W + 1)'(FACES);

    typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

    state_t                         state_q;
    logic [31:0]                    lfsr_q, lfsr_d;
    logic [31:0]                    cnt_q;
    logic                           seeded_q;
    logic [N_DICE-1:0]              hold_q;
    logic [IDX_W-1:0]               idx_q;
    logic [RETRY_W-1:0]             retry_q;
    logic [N_DICE-1:0][VAL_W-1:0]   dice_q;
    logic                           busy_q;
    logic                           done_q;
    logic [RL_W-1:0]                rolls_q;
    logic                           first_q;

    logic                           accept;
    logic [31:0]                    seed_mix;
    logic [VAL_W-1:0]               cand;
    logic                           cand_ok;
    logic [VAL_W-1:0]               draw_val;

    always_comb begin
        accept   = (state_q == IDLE) && roll_req && !new_turn && (rolls_q != '0);
        seed_mix = lfsr_q ^ cnt_q;
        lfsr_d   = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        // First accepted roll folds in the entropy counter; a zero mix would lock up the LFSR.
        if (accept && !seeded_q) begin
            lfsr_d = (seed_mix == '0) ? LFSR_SEED : seed_mix;
        end
        cand    = lfsr_q[VAL_W-1:0];
        cand_ok = ({1'b0, cand} < FACES_V);
        // With FACES == 2**VAL_W the top face FACES wraps to code 0 in VAL_W bits.
        if (cand_ok) begin
            draw_val = cand + 1'b1;
        end else begin
            draw_val = VAL_W'(({1'b0, cand} % FACES_V) + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            cnt_q    <= '0;
            seeded_q <= 1'b0;
            hold_q   <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            dice_q   <= {N_DICE{VAL_W'(1)}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rolls_q  <= MAX_ROLLS_V;
            first_q  <= 1'b1;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_q + 1'b1;
            done_q <= 1'b0;
            if (accept) begin
                seeded_q <= 1'b1;
            end
            if (new_turn) begin
                rolls_q <= MAX_ROLLS_V;
                first_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            hold_q  <= first_q ? '0 : hold;
                            idx_q   <= '0;
                            retry_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ROLL;
                        end
                    end
                    ROLL: begin
                        if (hold_q[idx_q] || cand_ok || (retry_q == MAX_RETRY_V)) begin
                            if (!hold_q[idx_q]) begin
                                dice_q[idx_q] <= draw_val;
                            end
                            retry_q <= '0;
                            if (idx_q == LAST_IDX) begin
                                state_q <= DONE;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            retry_q <= retry_q + 1'b1;
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        rolls_q <= rolls_q - 1'b1;
                        first_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dice_vals  = dice_q;
    assign busy       = busy_q;
    assign roll_done  = done_q;
    assign rolls_left = rolls_q;
    assign first_roll = first_q;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Bench for dice_roll_engine: two configurations (6-face/5 dice and 8-face/4 dice)
// checked roll by roll against a procedural model of draws, rejections and budget.
module tb_dice_roll_engine;

    localparam logic [31:0] SEED      = 32'h0000ACE1;
    localparam int          MAX_RETRY = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rr0 = 1'b0, nt0 = 1'b0, rr1 = 1'b0, nt1 = 1'b0;
    logic [4:0]  hold0 = '0;
    logic [3:0]  hold1 = '0;
    logic [14:0] dv0;
    logic [11:0] dv1;
    logic        busy0, rd0, fr0, busy1, rd1, fr1;
    logic [1:0]  rl0, rl1;

    int errors = 0;
    int checks = 0;

    logic [31:0] mlfsr [2];
    logic [31:0] mcnt;
    bit          mseed [2];
    int          md [2][8];
    int          mrl [2];
    bit          mfr [2];
    int          pd [8];

    always #5 clk = ~clk;

    dice_roll_engine #(.N_DICE(5), .FACES(6), .VAL_W(3), .MAX_ROLLS(3),
                       .MAX_RETRY(7), .LFSR_SEED(SEED)) u_dut (
        .clk(clk), .reset_n(reset_n), .roll_req(rr0), .new_turn(nt0), .hold(hold0),
        .dice_vals(dv0), .busy(busy0), .roll_done(rd0), .rolls_left(rl0), .first_roll(fr0));

    dice_roll_engine #(.N_DICE(4), .FACES(8), .VAL_W(3), .MAX_ROLLS(3),
                       .MAX_RETRY(7), .LFSR_SEED(SEED)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .roll_req(rr1), .new_turn(nt1), .hold(hold1),
        .dice_vals(dv1), .busy(busy1), .roll_done(rd1), .rolls_left(rl1), .first_roll(fr1));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic int field(input int k, input int i);
        if (k == 0) return int'(dv0[i*3 +: 3]);
        return int'(dv1[i*3 +: 3]);
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcnt = 0;
        for (int k = 0; k < 2; k++) begin
            mlfsr[k] = SEED;
            mseed[k] = 0;
            mrl[k]   = 3;
            mfr[k]   = 1;
            for (int i = 0; i < 8; i++) md[k][i] = 1;
        end
    endtask

    // One clock edge; the model LFSR either steps or, on a first accept, takes the seed mix.
    task automatic tick(input bit acc0, input bit acc1);
        bit          acc [2];
        logic [31:0] mix;
        acc[0] = acc0;
        acc[1] = acc1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc[k] && !mseed[k]) begin
                mix      = mlfsr[k] ^ mcnt;
                mlfsr[k] = (mix == 0) ? SEED : mix;
                mseed[k] = 1;
            end else begin
                mlfsr[k] = lfsr_next(mlfsr[k]);
            end
        end
        mcnt = mcnt + 1;
        #1;
    endtask

    // Plays out one roll from the LFSR value seen in the first ROLL cycle; lat counts edges to roll_done.
    task automatic predict(input logic [31:0] l0, input int faces, input int nd,
                           input logic [7:0] h, output int lat);
        logic [31:0] l;
        int          tries, cand;
        bit          placed;
        l   = l0;
        lat = 1;
        for (int i = 0; i < nd; i++) begin
            if (h[i]) begin
                l = lfsr_next(l);
                lat++;
            end else begin
                tries  = 0;
                placed = 0;
                while (!placed) begin
                    cand = int'(l[2:0]);
                    l = lfsr_next(l);
                    lat++;
                    if (cand < faces) begin
                        pd[i] = cand + 1;
                        placed = 1;
                    end else if (tries >= MAX_RETRY) begin
                        pd[i] = cand % faces + 1;
                        placed = 1;
                    end else begin
                        tries++;
                    end
                end
            end
        end
    endtask

    task automatic do_roll(input int k, input logic [7:0] hold, output int n);
        int         nd, faces, lat;
        logic [7:0] h;
        nd    = (k == 0) ? 5 : 4;
        faces = (k == 0) ? 6 : 8;
        h     = mfr[k] ? 8'h00 : hold;
        if (k == 0) begin rr0 = 1'b1; hold0 = hold[4:0]; end
        else        begin rr1 = 1'b1; hold1 = hold[3:0]; end
        tick(k == 0, k == 1);
        rr0 = 1'b0;
        rr1 = 1'b0;
        hold0 = 5'($urandom);
        hold1 = 4'($urandom);
        check($sformatf("busy_after_accept_%0d", k), (k == 0) ? busy0 : busy1, 1);
        for (int i = 0; i < 8; i++) pd[i] = md[k][i];
        predict(mlfsr[k], faces, nd, h, lat);
        n = 0;
        while (((k == 0) ? rd0 : rd1) == 1'b0 && n < 200) begin
            tick(0, 0);
            n++;
        end
        check($sformatf("latency_%0d", k), n, lat);
        for (int i = 0; i < 8; i++) md[k][i] = pd[i];
        for (int i = 0; i < nd; i++)
            check($sformatf("die_%0d_%0d", k, i), field(k, i), md[k][i] % 8);
        mrl[k] = mrl[k] - 1;
        mfr[k] = 0;
        check($sformatf("rolls_left_%0d", k), (k == 0) ? rl0 : rl1, mrl[k]);
        check($sformatf("first_roll_%0d", k), (k == 0) ? fr0 : fr1, mfr[k]);
        check($sformatf("busy_at_done_%0d", k), (k == 0) ? busy0 : busy1, 0);
        tick(0, 0);
        check($sformatf("done_pulse_width_%0d", k), (k == 0) ? rd0 : rd1, 0);
    endtask

    task automatic do_new_turn(input int k);
        if (k == 0) nt0 = 1'b1; else nt1 = 1'b1;
        tick(0, 0);
        nt0 = 1'b0;
        nt1 = 1'b0;
        mrl[k] = 3;
        mfr[k] = 1;
        check($sformatf("new_turn_rl_%0d", k), (k == 0) ? rl0 : rl1, 3);
        check($sformatf("new_turn_fr_%0d", k), (k == 0) ? fr0 : fr1, 1);
    endtask

    initial begin
        int n;
        int saved [8];
        bit seen;
        int face_cnt [7];
        bit cov [8];

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) check("reset_die", field(0, i), 1);
        check("reset_busy", busy0, 0);
        check("reset_done", rd0, 0);
        check("reset_rl", rl0, 3);
        check("reset_fr", fr0, 1);
        reset_n = 1'b1;
        repeat (4) tick(0, 0);

        // Budget: three rolls, then a refused fourth, then a new turn.
        do_roll(0, 8'($urandom), n);
        do_roll(0, 8'($urandom), n);
        do_roll(0, 8'($urandom), n);
        rr0 = 1'b1;
        tick(0, 0);
        rr0 = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            seen = seen | busy0 | rd0;
            tick(0, 0);
        end
        check("exhausted_no_roll", seen, 0);
        check("exhausted_rl", rl0, 0);
        do_new_turn(0);

        // Hold: ignored on the first roll of a turn, honoured afterwards.
        do_roll(0, 8'h1F, n);
        for (int i = 0; i < 5; i++) saved[i] = md[0][i];
        do_roll(0, 8'h15, n);
        check("hold_die0", field(0, 0), saved[0]);
        check("hold_die2", field(0, 2), saved[2]);
        check("hold_die4", field(0, 4), saved[4]);

        // new_turn beats a same-cycle roll_req in IDLE.
        rr0 = 1'b1;
        nt0 = 1'b1;
        tick(0, 0);
        rr0 = 1'b0;
        nt0 = 1'b0;
        mrl[0] = 3;
        mfr[0] = 1;
        check("collide_busy", busy0, 0);
        check("collide_rl", rl0, 3);
        check("collide_fr", fr0, 1);
        tick(0, 0);
        check("collide_no_start", busy0, 0);

        // new_turn in the second ROLL cycle aborts without a completion.
        rr0 = 1'b1;
        tick(1, 0);
        rr0 = 1'b0;
        tick(0, 0);
        check("abort_busy_before", busy0, 1);
        nt0 = 1'b1;
        tick(0, 0);
        nt0 = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_rl", rl0, 3);
        check("abort_fr", fr0, 1);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            seen = seen | rd0 | busy0;
            tick(0, 0);
        end
        check("abort_no_done", seen, 0);

        // Asynchronous reset in the middle of a roll.
        do_roll(0, 8'($urandom), n);
        rr0 = 1'b1;
        tick(0 + 1, 0);
        rr0 = 1'b0;
        tick(0, 0);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) check("midroll_reset_die", field(0, i), 1);
        check("midroll_reset_busy", busy0, 0);
        check("midroll_reset_rl", rl0, 3);
        check("midroll_reset_fr", fr0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(0, 0);

        // 8 faces in 3 bits: no rejection, fixed latency, every code reachable.
        for (int v = 0; v < 8; v++) cov[v] = 0;
        for (int r = 0; r < 40; r++) begin
            if (mrl[1] == 0) do_new_turn(1);
            do_roll(1, 8'($urandom & $urandom), n);
            check("t5_latency_fixed", n, 5);
            for (int i = 0; i < 4; i++) cov[field(1, i)] = 1;
        end
        for (int v = 0; v < 8; v++) check($sformatf("t5_code_%0d_seen", v), cov[v], 1);

        // Long run of unheld rolls for face distribution.
        for (int f = 0; f < 7; f++) face_cnt[f] = 0;
        for (int r = 0; r < 1200; r++) begin
            if (mrl[0] == 0) do_new_turn(0);
            do_roll(0, 8'h00, n);
            check("t4_latency_min", (n >= 6), 1);
            for (int i = 0; i < 5; i++) begin
                check("t4_range", (field(0, i) >= 1 && field(0, i) <= 6), 1);
                if (field(0, i) >= 1 && field(0, i) <= 6) face_cnt[field(0, i)]++;
            end
        end
        for (int f = 1; f <= 6; f++)
            check($sformatf("t4_face_%0d_count_within_15pct", f),
                  (face_cnt[f] >= 850 && face_cnt[f] <= 1150), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
